// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath (shared ALU, unified memory).
// Outputs are decoded combinationally from state, OpCode/Funct and mem_ready.
module multicycle_control #(
    parameter int unsigned WAIT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       ExtOp,
    output logic       LuOp,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    state_t            state, nextState;
    logic [WAIT_W-1:0] waitCnt, nextWaitCnt;
    logic              waiting, timeout;

    logic isR, isRAlu, isShift, isJr, isJalr, isJ, isJal, isBeq;
    logic isLw, isSw, isAndi, isLui, isImm, legal;

    // Zero is ANDed with PCWriteCond in the datapath; it never steers sequencing.
    logic unusedZero;
    assign unusedZero = Zero;

    // Instruction class decode from the IR fields
    always_comb begin
        isR     = (OpCode == OP_RTYPE);
        isRAlu  = 1'b0;
        isShift = 1'b0;
        isJr    = 1'b0;
        isJalr  = 1'b0;
        if (isR) begin
            case (Funct)
                FN_SLL, FN_SRL, FN_SRA: begin
                    isRAlu  = 1'b1;
                    isShift = 1'b1;
                end
                FN_JR:   isJr   = 1'b1;
                FN_JALR: isJalr = 1'b1;
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                FN_XOR, FN_NOR, FN_SLT, FN_SLTU: isRAlu = 1'b1;
                default: ;
            endcase
        end
        isJ    = (OpCode == OP_J);
        isJal  = (OpCode == OP_JAL);
        isBeq  = (OpCode == OP_BEQ);
        isLw   = (OpCode == OP_LW);
        isSw   = (OpCode == OP_SW);
        isAndi = (OpCode == OP_ANDI);
        isLui  = (OpCode == OP_LUI);
        isImm  = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) || (OpCode == OP_SLTI) ||
                 (OpCode == OP_SLTIU) || isAndi || isLui;
        legal  = isRAlu || isJr || isJalr || isJ || isJal || isBeq || isLw || isSw || isImm;
    end

    // Memory-wait watchdog
    assign waiting     = ((state == FETCH) || (state == MEM)) && !mem_ready;
    assign timeout     = waiting && (waitCnt == WAIT_MAX);
    assign nextWaitCnt = (waiting && !timeout) ? waitCnt + WAIT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next state and per-cycle control; everything held at 0 during reset
    always_comb begin
        nextState   = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_error   = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        nextState = DECODE;
                    end else if (timeout) begin
                        bus_error = 1'b1;
                    end
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    ExtOp   = 1'b1;
                    if (isJ || isJal) begin
                        PCWrite    = 1'b1;
                        PCSource   = 2'b10;
                        instr_done = 1'b1;
                        nextState  = FETCH;
                        if (isJal) begin
                            RegWrite = 1'b1;
                            RegDst   = 2'b10;
                            MemtoReg = 2'b10;
                        end
                    end else if (isJr || isJalr) begin
                        PCWrite    = 1'b1;
                        PCSource   = 2'b11;
                        instr_done = 1'b1;
                        nextState  = FETCH;
                        if (isJalr) begin
                            RegWrite = 1'b1;
                            RegDst   = 2'b01;
                            MemtoReg = 2'b10;
                        end
                    end else if (!legal) begin
                        illegal   = 1'b1;
                        nextState = FETCH;
                    end else begin
                        nextState = EXEC;
                    end
                end
                EXEC: begin
                    ALUOp   = 2'b01;
                    ALUSrcA = isShift ? 2'b10 : 2'b01;
                    if (isR) begin
                        nextState = WB;
                    end else if (isBeq) begin
                        PCWriteCond = 1'b1;
                        PCSource    = 2'b01;
                        instr_done  = 1'b1;
                        nextState   = FETCH;
                    end else if (isLw || isSw) begin
                        ALUSrcB   = 2'b10;
                        ExtOp     = 1'b1;
                        ALUOp     = 2'b00;
                        nextState = MEM;
                    end else begin
                        ALUSrcB   = 2'b10;
                        ExtOp     = !isAndi;
                        LuOp      = isLui;
                        nextState = WB;
                    end
                end
                MEM: begin
                    IorD     = 1'b1;
                    MemRead  = isLw;
                    MemWrite = isSw;
                    if (mem_ready) begin
                        if (isLw) begin
                            nextState = WB;
                        end else begin
                            instr_done = 1'b1;
                            nextState  = FETCH;
                        end
                    end else if (timeout) begin
                        bus_error = 1'b1;
                        nextState = FETCH;
                    end
                end
                WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    RegDst     = isR ? 2'b01 : 2'b00;
                    MemtoReg   = isLw ? 2'b01 : 2'b00;
                    nextState  = FETCH;
                end
                default: nextState = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its
// expected per-cycle control vectors from the ISA rules, then replayed against the DUT.
module tb_multicycle_control;
    logic       clk, reset, Zero, mem_ready;
    logic [5:0] OpCode, Funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] PCSource, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp;
    logic       ExtOp, LuOp, instr_done, illegal, bus_error;

    multicycle_control #(.WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .LuOp(LuOp),
        .instr_done(instr_done), .illegal(illegal), .bus_error(bus_error)
    );

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic [1:0] regDst;
        logic [1:0] memtoReg;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       extOp;
        logic       luOp;
        logic       instrDone;
        logic       illegal;
        logic       busError;
    } ctl_t;

    typedef struct packed {
        ctl_t exp;
        logic rdy;
        logic fetch;
    } step_t;

    typedef enum logic [3:0] {
        K_RALU, K_SHIFT, K_JR, K_JALR, K_J, K_JAL, K_BEQ, K_LW, K_SW, K_IMM, K_ANDI, K_LUI, K_ILL
    } kind_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       fnFixed;
        kind_t      kind;
    } instr_t;

    instr_t tbl[$];
    step_t  plan[$];
    ctl_t   actVec, expVec;
    logic   expValid;
    string  curTag;
    int     curStep;
    int     nVec, nMis;

    always_comb begin
        actVec.pcWrite     = PCWrite;
        actVec.pcWriteCond = PCWriteCond;
        actVec.pcSource    = PCSource;
        actVec.iorD        = IorD;
        actVec.memRead     = MemRead;
        actVec.memWrite    = MemWrite;
        actVec.irWrite     = IRWrite;
        actVec.regWrite    = RegWrite;
        actVec.regDst      = RegDst;
        actVec.memtoReg    = MemtoReg;
        actVec.aluSrcA     = ALUSrcA;
        actVec.aluSrcB     = ALUSrcB;
        actVec.aluOp       = ALUOp;
        actVec.extOp       = ExtOp;
        actVec.luOp        = LuOp;
        actVec.instrDone   = instr_done;
        actVec.illegal     = illegal;
        actVec.busError    = bus_error;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-cycle compare against the expected vector, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (expValid) begin
                nVec++;
                if (actVec !== expVec) begin
                    nMis++;
                    $display("FAIL %s step %0d: got %h want %h", curTag, curStep, actVec, expVec);
                end
            end
        end
    end

    function automatic void addI(input logic [5:0] op, input logic [5:0] fn, input kind_t k);
        instr_t e;
        e.op = op; e.fn = fn; e.fnFixed = (op == 6'h00); e.kind = k;
        tbl.push_back(e);
    endfunction

    function automatic void addStep(input ctl_t v, input logic rdy, input logic isFetch);
        step_t s;
        s.exp = v; s.rdy = rdy; s.fetch = isFetch;
        plan.push_back(s);
    endfunction

    function automatic ctl_t fetchVec(input logic rdy);
        ctl_t v = '0;
        v.memRead = 1'b1;
        v.aluSrcB = 2'b01;
        v.irWrite = rdy;
        v.pcWrite = rdy;
        return v;
    endfunction

    // Expand one instruction into its cycle-by-cycle control vectors
    function automatic void buildPlan(input kind_t k, input int fW, input int mW);
        ctl_t v;
        plan.delete();
        for (int i = 0; i < fW; i++) addStep(fetchVec(1'b0), 1'b0, 1'b1);
        addStep(fetchVec(1'b1), 1'b1, 1'b1);
        v = '0; v.aluSrcB = 2'b11; v.extOp = 1'b1;
        case (k)
            K_J, K_JAL: begin
                v.pcWrite = 1'b1; v.pcSource = 2'b10; v.instrDone = 1'b1;
                if (k == K_JAL) begin v.regWrite = 1'b1; v.regDst = 2'b10; v.memtoReg = 2'b10; end
            end
            K_JR, K_JALR: begin
                v.pcWrite = 1'b1; v.pcSource = 2'b11; v.instrDone = 1'b1;
                if (k == K_JALR) begin v.regWrite = 1'b1; v.regDst = 2'b01; v.memtoReg = 2'b10; end
            end
            K_ILL: v.illegal = 1'b1;
            default: ;
        endcase
        addStep(v, 1'($urandom), 1'b0);
        if (k inside {K_J, K_JAL, K_JR, K_JALR, K_ILL}) return;
        v = '0; v.aluOp = 2'b01; v.aluSrcA = (k == K_SHIFT) ? 2'b10 : 2'b01;
        case (k)
            K_RALU, K_SHIFT: v.aluSrcB = 2'b00;
            K_BEQ: begin v.pcWriteCond = 1'b1; v.pcSource = 2'b01; v.instrDone = 1'b1; end
            K_LW, K_SW: begin v.aluSrcB = 2'b10; v.extOp = 1'b1; v.aluOp = 2'b00; end
            default: begin v.aluSrcB = 2'b10; v.extOp = (k != K_ANDI); v.luOp = (k == K_LUI); end
        endcase
        addStep(v, 1'($urandom), 1'b0);
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            v = '0; v.iorD = 1'b1; v.memRead = (k == K_LW); v.memWrite = (k == K_SW);
            if (mW >= 16) begin
                for (int i = 0; i < 15; i++) addStep(v, 1'b0, 1'b0);
                v.busError = 1'b1;
                addStep(v, 1'b0, 1'b0);
                return;
            end
            for (int i = 0; i < mW; i++) addStep(v, 1'b0, 1'b0);
            if (k == K_SW) v.instrDone = 1'b1;
            addStep(v, 1'b1, 1'b0);
            if (k == K_SW) return;
        end
        v = '0; v.regWrite = 1'b1; v.instrDone = 1'b1;
        v.regDst   = (k == K_RALU || k == K_SHIFT) ? 2'b01 : 2'b00;
        v.memtoReg = (k == K_LW) ? 2'b01 : 2'b00;
        addStep(v, 1'($urandom), 1'b0);
    endfunction

    // Drive one cycle; IR fields are garbage while fetching
    task automatic applyStep(input int idx, input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_ready = plan[idx].rdy;
        Zero      = z;
        OpCode    = plan[idx].fetch ? 6'($urandom) : op;
        Funct     = plan[idx].fetch ? 6'($urandom) : fn;
        expVec    = plan[idx].exp;
        curStep   = idx;
        expValid  = 1'b1;
    endtask

    task automatic playRange(input int from, input int upto, input logic [5:0] op, input logic [5:0] fn);
        for (int i = from; i < upto; i++) applyStep(i, op, fn, 1'($urandom));
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset     = 1'b1;
            mem_ready = 1'($urandom);
            OpCode    = 6'($urandom);
            Funct     = 6'($urandom);
            expVec    = '0;
            curTag    = "reset";
            curStep   = i;
            expValid  = 1'b1;
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        int idx, fW, mW, r, stop;
        logic [5:0] fn;
        reset = 1'b1; Zero = 1'b0; mem_ready = 1'b0; OpCode = '0; Funct = '0;
        expValid = 1'b0; expVec = '0; curTag = "init"; curStep = 0; nVec = 0; nMis = 0;

        for (int f = 6'h20; f <= 6'h27; f++) addI(6'h00, 6'(f), K_RALU);
        addI(6'h00, 6'h2A, K_RALU); addI(6'h00, 6'h2B, K_RALU);
        addI(6'h00, 6'h00, K_SHIFT); addI(6'h00, 6'h02, K_SHIFT); addI(6'h00, 6'h03, K_SHIFT);
        addI(6'h00, 6'h08, K_JR); addI(6'h00, 6'h09, K_JALR);
        addI(6'h02, 6'h00, K_J); addI(6'h03, 6'h00, K_JAL); addI(6'h04, 6'h00, K_BEQ);
        addI(6'h23, 6'h00, K_LW); addI(6'h2B, 6'h00, K_SW);
        addI(6'h08, 6'h00, K_IMM); addI(6'h09, 6'h00, K_IMM); addI(6'h0A, 6'h00, K_IMM);
        addI(6'h0B, 6'h00, K_IMM); addI(6'h0C, 6'h00, K_ANDI); addI(6'h0F, 6'h00, K_LUI);
        addI(6'h3F, 6'h00, K_ILL); addI(6'h05, 6'h00, K_ILL); addI(6'h0D, 6'h00, K_ILL);
        addI(6'h00, 6'h01, K_ILL); addI(6'h00, 6'h2C, K_ILL); addI(6'h00, 6'h3F, K_ILL);

        doReset(2);

        // T1: reset for 2 cycles while lw is stalled in MEM
        curTag = "t1_lw";
        buildPlan(K_LW, 0, 3);
        playRange(0, 4, 6'h23, 6'h11);
        doReset(2);
        // T2: add with no stalls, and first FETCH after reset
        curTag = "t2_add";
        buildPlan(K_RALU, 0, 0);
        lit("add_len", plan.size(), 4);
        applyStep(0, 6'h00, 6'h20, 1'b0);
        #2;
        lit("t1_fetch_memread", int'(MemRead), 1);
        lit("t1_fetch_iord", int'(IorD), 0);
        playRange(1, 4, 6'h00, 6'h20);
        #2;
        lit("t2_wb_regdst", int'(RegDst), 1);
        lit("t2_wb_done", int'(instr_done), 1);

        // T3: lw with 3 stalled MEM cycles
        curTag = "t3_lw";
        buildPlan(K_LW, 0, 3);
        lit("lw3_len", plan.size(), 8);
        playRange(0, 8, 6'h23, 6'h05);
        #2;
        lit("t3_wb_memtoreg", int'(MemtoReg), 1);

        // T4: beq with Zero high then low
        for (int z = 1; z >= 0; z--) begin
            curTag = "t4_beq";
            buildPlan(K_BEQ, 0, 0);
            lit("beq_len", plan.size(), 3);
            applyStep(0, 6'h04, 6'h00, 1'(z));
            applyStep(1, 6'h04, 6'h00, 1'(z));
            applyStep(2, 6'h04, 6'h00, 1'(z));
            #2;
            lit("t4_pcwritecond", int'(PCWriteCond), 1);
            lit("t4_pcsource", int'(PCSource), 1);
        end

        // T5: jal completes in DECODE
        curTag = "t5_jal";
        buildPlan(K_JAL, 0, 0);
        lit("jal_len", plan.size(), 2);
        playRange(0, 2, 6'h03, 6'h00);
        #2;
        lit("t5_pcsource", int'(PCSource), 2);
        lit("t5_regdst", int'(RegDst), 2);
        lit("t5_memtoreg", int'(MemtoReg), 2);

        // T6: illegal opcode, then sw that times out
        curTag = "t6_ill";
        buildPlan(K_ILL, 0, 0);
        playRange(0, 2, 6'h3F, 6'h00);
        #2;
        lit("t6_illegal", int'(illegal), 1);
        lit("t6_ill_regwrite", int'(RegWrite), 0);
        curTag = "t6_sw";
        buildPlan(K_SW, 0, 16);
        lit("sw_to_len", plan.size(), 19);
        playRange(0, 19, 6'h2B, 6'h00);
        #2;
        lit("t6_bus_error", int'(bus_error), 1);
        curTag = "t6_after";
        buildPlan(K_SW, 0, 0);
        lit("sw_len", plan.size(), 4);
        applyStep(0, 6'h2B, 6'h00, 1'b0);
        #2;
        lit("t6_after_memwrite", int'(MemWrite), 0);
        playRange(1, 4, 6'h2B, 6'h00);

        // Randomized instruction stream with occasional stalls, timeouts and resets
        for (int n = 0; n < 300; n++) begin
            idx = $urandom_range(tbl.size() - 1, 0);
            fn  = tbl[idx].fnFixed ? tbl[idx].fn : 6'($urandom);
            r   = $urandom_range(19, 0);
            fW  = (r < 17) ? r % 3 : 15;
            r   = $urandom_range(19, 0);
            mW  = (r < 13) ? r % 4 : ((r < 16) ? 15 : 16);
            buildPlan(tbl[idx].kind, fW, mW);
            curTag = tbl[idx].kind.name();
            stop = plan.size();
            if ($urandom_range(11, 0) == 0) stop = $urandom_range(plan.size() - 1, 1);
            playRange(0, stop, tbl[idx].op, fn);
            if (stop != plan.size()) doReset($urandom_range(2, 1));
        end

        @(posedge clk);
        #1;
        expValid = 1'b0;
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
